// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master/slave pair.
// The master's state enum lives here so both ends draw from one package.
package spi_pkg;

    localparam int SPI_DATA_W    = 8;
    localparam int SPI_SCLK_HALF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        SHIFT,
        DONE,
        WAIT_CS
    } rx_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_START,
        M_DATA,
        M_STOP
    } master_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage flip-flop synchronizer for one asynchronous SPI line.
// The reset value is a parameter so an idle line (e.g. cs high) looks idle out of reset.
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Receive side of the SPI link: synchronizes sclk/cs/mosi, drops the master's
// lead-in pulse, shifts in one frame MSB-first and presents it on a valid/ready port.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int LEAD_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LW = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [LW-1:0] LAST_LEAD = LW'((LEAD_EDGES > 0) ? LEAD_EDGES - 1 : 0);
    localparam rx_state_t     FIRST_ST  = (LEAD_EDGES == 0) ? SHIFT : SKIP;

    logic sclk_s, cs_s, mosi_s;
    logic sck_rise_d;

    rx_state_t         state_q;
    logic [LW-1:0]     lead_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              busy_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              sclk_prev_q;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(cs), .q_o(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s)
    );

    assign sck_rise_d = sclk_s & ~sclk_prev_q;

    // cs rising in SKIP/SHIFT is an abort; in DONE/WAIT_CS it is the normal frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lead_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!cs_s) begin
                        state_q    <= FIRST_ST;
                        lead_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SKIP: begin
                    if (cs_s) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        shreg_q     <= '0;
                    end else if (sck_rise_d) begin
                        lead_cnt_q <= lead_cnt_q + LW'(1);
                        if (lead_cnt_q == LAST_LEAD) begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        shreg_q     <= '0;
                    end else if (sck_rise_d) begin
                        shreg_q   <= {shreg_q[DATA_W-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!dout_valid_q || dout_ready) begin
                        dout_q       <= shreg_q;
                        dout_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= WAIT_CS;
                end
                WAIT_CS: begin
                    if (cs_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: drives master-style SPI frames on the pins
// and checks the output port against a frame-level scoreboard model.
module tb_spi_slave_rx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic              mosi = 1'b0;
    logic              dout_ready = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    int checks = 0;
    int failures = 0;

    // Frame-level model: bytes the port must present, in order, and pulse totals.
    logic [DATA_W-1:0] expQ[$];
    bit                held = 1'b0;
    int                expFe = 0;
    int                expOv = 0;
    int                feSeen = 0;
    int                ovSeen = 0;
    int                validCycles = 0;
    logic [DATA_W-1:0] lastLoad = '0;

    spi_slave_rx #(.DATA_W(DATA_W), .LEAD_EDGES(1), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle compare: loads must match the scoreboard, held bytes must not move,
    // accepted bytes must clear, pulses must be one cycle wide.
    logic              prevValid = 1'b0;
    logic              prevReady = 1'b0;
    logic              prevFe = 1'b0;
    logic              prevOv = 1'b0;
    logic [DATA_W-1:0] prevDout = '0;

    always @(negedge clk) begin
        logic loadEv;
        if (!rst) begin
            checkOutput("reset_dout", dout, 0);
            checkOutput("reset_valid", dout_valid, 0);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_frame_err", frame_err, 0);
            checkOutput("reset_overrun", overrun, 0);
            prevValid = 1'b0;
            prevReady = 1'b0;
            prevFe    = 1'b0;
            prevOv    = 1'b0;
            prevDout  = '0;
        end else begin
            loadEv = dout_valid && (!prevValid || dout != prevDout);
            if (dout_valid) validCycles++;
            if (loadEv) begin
                lastLoad = dout;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_load actual=0x%0h required=no_load", dout);
                end else begin
                    checkOutput("load_byte", dout, expQ.pop_front());
                end
            end
            if (prevValid && !prevReady) begin
                checkOutput("hold_valid", dout_valid, 1);
                checkOutput("hold_dout", dout, prevDout);
            end else if (prevValid && prevReady && !loadEv) begin
                checkOutput("consume_clears", dout_valid, 0);
            end
            if (frame_err) begin
                feSeen++;
                checkOutput("frame_err_width", prevFe, 0);
            end
            if (overrun) begin
                ovSeen++;
                checkOutput("overrun_width", prevOv, 0);
            end
            prevValid = dout_valid;
            prevReady = dout_ready;
            prevFe    = frame_err;
            prevOv    = overrun;
            prevDout  = dout;
        end
    end

    // One master frame: lead-in pulse, nBits data pulses, stop pulse and cs release.
    // nBits < DATA_W aborts (or resets, if resetMid) after that many data edges.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input int nBits,
                                 input bit pulseReady, input bit checkTiming, input bit resetMid);
        cs   = 1'b0;
        mosi = 1'b0;
        repeat (HALF) tick();
        sclk = 1'b1;
        repeat (HALF) tick();
        sclk = 1'b0;
        checkOutput("busy_in_frame", busy, 1);
        for (int i = 0; i < nBits; i++) begin
            mosi = data[DATA_W-1-i];
            repeat (HALF) tick();
            if (i == DATA_W - 1) begin
                if (!held || dout_ready || pulseReady) begin
                    expQ.push_back(data);
                    held = !dout_ready;
                end else begin
                    expOv++;
                end
            end
            sclk = 1'b1;
            if (i == DATA_W - 1 && (pulseReady || checkTiming)) begin
                repeat (SYNC_STAGES + 1) tick();
                if (checkTiming) checkOutput("valid_not_early", dout_valid, 0);
                if (pulseReady) dout_ready = 1'b1;
                tick();
                if (pulseReady) dout_ready = 1'b0;
                if (checkTiming) begin
                    checkOutput("valid_latency", dout_valid, 1);
                    checkOutput("valid_latency_dout", dout, data);
                end
                repeat (HALF - SYNC_STAGES - 2) tick();
            end else begin
                repeat (HALF) tick();
            end
            sclk = 1'b0;
        end
        if (resetMid) begin
            rst = 1'b0;
            #1;
            checkOutput("midreset_dout", dout, 0);
            checkOutput("midreset_valid", dout_valid, 0);
            checkOutput("midreset_busy", busy, 0);
            checkOutput("midreset_frame_err", frame_err, 0);
            held = 1'b0;
            cs = 1'b1;
            repeat (3) tick();
            rst = 1'b1;
        end else if (nBits < DATA_W) begin
            cs = 1'b1;
            expFe++;
        end else begin
            repeat (HALF) tick();
            sclk = 1'b1;
            repeat (HALF) tick();
            sclk = 1'b0;
            repeat (HALF) tick();
            cs = 1'b1;
        end
        mosi = 1'b0;
        repeat (12) tick();
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("frame_err_count", feSeen, expFe);
        checkOutput("overrun_count", ovSeen, expOv);
    endtask

    initial begin
        int nb;
        $display("[TB] start");

        // Reset held with random pin activity.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sclk = 1'($urandom_range(0, 1));
            cs   = 1'($urandom_range(0, 1));
            mosi = 1'($urandom_range(0, 1));
            dout_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        dout_ready = 1'b1;
        tick();
        rst = 1'b1;
        repeat (6) tick();

        // Basic transfers with the consumer always ready.
        held = 1'b0;
        validCycles = 0;
        applyStimulus(8'hA5, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_value", lastLoad, 8'hA5);
        checkOutput("a5_valid_cycles", validCycles, 1);
        applyStimulus(8'h3C, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("3c_value", lastLoad, 8'h3C);

        // Overrun: second byte dropped while the first is unconsumed.
        dout_ready = 1'b0;
        applyStimulus(8'h81, DATA_W, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h7E, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun_keeps_81", dout, 8'h81);
        checkOutput("overrun_pulses", ovSeen, 1);
        dout_ready = 1'b1;
        held = 1'b0;
        repeat (2) tick();
        checkOutput("overrun_drained", dout_valid, 0);

        // Abort after 4 data edges, then a clean frame.
        applyStimulus(8'hC3, 4, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_frame_err", feSeen, 1);
        checkOutput("abort_no_valid", dout_valid, 0);
        applyStimulus(8'hFF, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("ff_value", lastLoad, 8'hFF);

        // Reset after 3 data bits, then a clean frame.
        applyStimulus(8'hE7, 3, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h55, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("55_value", lastLoad, 8'h55);
        checkOutput("midreset_no_frame_err", feSeen, 1);

        // Consume and load in the same DONE cycle.
        dout_ready = 1'b0;
        applyStimulus(8'h12, DATA_W, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_12", dout, 8'h12);
        applyStimulus(8'h34, DATA_W, 1'b1, 1'b0, 1'b0);
        checkOutput("swap_34", dout, 8'h34);
        checkOutput("swap_valid", dout_valid, 1);
        checkOutput("swap_no_overrun", ovSeen, 1);
        dout_ready = 1'b1;
        held = 1'b0;
        repeat (2) tick();

        // Randomized frames, consumer readiness and occasional aborts.
        for (int f = 0; f < 24; f++) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (dout_ready) held = 1'b0;
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DATA_W - 1)) : DATA_W;
            applyStimulus(DATA_W'($urandom), nb, 1'b0, 1'b0, 1'b0);
        end

        dout_ready = 1'b1;
        held = 1'b0;
        repeat (4) tick();
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("final_valid", dout_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
